// File: rtl/draw_crosshair_param_pkg.sv
// Shared types and widths for the crosshair drawer and its helpers.
package crosshair_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM_A = 2'd1,
    ARM_B = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Default visible screen size of the VGA adapter
  localparam int SCREEN_W_DFLT = 160;
  localparam int SCREEN_H_DFLT = 120;

  // Unsigned VGA port widths
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 18;

  // Signed working widths for pixel arithmetic (room for negative offsets)
  localparam int SX_W = 9;
  localparam int SY_W = 8;

endpackage

// File: rtl/draw_crosshair_param_if.sv
// Control and VGA write-port bundle for draw_crosshair_param.
// The erase input exists only when DRAW_CROSSHAIR_ERASE_EN is defined.
interface draw_crosshair_param_if;
  import crosshair_pkg::*;

  logic             start;
  logic             mode;
  logic [X_W-1:0]   center_x;
  logic [Y_W-1:0]   center_y;
`ifdef DRAW_CROSSHAIR_ERASE_EN
  logic             erase;
`endif
  logic             done;
  logic             busy;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [COL_W-1:0] vga_colour;
  logic             vga_write;

  // Renderer side: issues draw requests, observes progress and pixels
  modport master (
    output start, mode, center_x, center_y,
`ifdef DRAW_CROSSHAIR_ERASE_EN
    erase,
`endif
    input  done, busy, vga_x, vga_y, vga_colour, vga_write
  );

  // Drawer side
  modport slave (
    input  start, mode, center_x, center_y,
`ifdef DRAW_CROSSHAIR_ERASE_EN
    erase,
`endif
    output done, busy, vga_x, vga_y, vga_colour, vga_write
  );

endinterface

// File: rtl/crosshair_clip.sv
// Screen clipping helper: flags whether a signed pixel coordinate lies on the
// visible screen and truncates it to the VGA port widths. Purely combinational.
module crosshair_clip
  import crosshair_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DFLT,
  parameter int SCREEN_H = SCREEN_H_DFLT
) (
  input  logic signed [SX_W-1:0] i_x,
  input  logic signed [SY_W-1:0] i_y,
  output logic                   o_in_bounds,
  output logic [X_W-1:0]         o_x,
  output logic [Y_W-1:0]         o_y
);

  localparam logic signed [SX_W-1:0] X_LIM = SX_W'(SCREEN_W);
  localparam logic signed [SY_W-1:0] Y_LIM = SY_W'(SCREEN_H);

  // Negative coordinates are caught by the sign bit, the far edges by compare
  assign o_in_bounds = !i_x[SX_W-1] && (i_x < X_LIM) &&
                       !i_y[SY_W-1] && (i_y < Y_LIM);
  assign o_x = i_x[X_W-1:0];
  assign o_y = i_y[Y_W-1:0];

endmodule

// File: rtl/draw_crosshair_param.sv
// Parametrised crosshair drawer: on start, walks every (arm, t, d) pair of a
// plus or X shaped crosshair, one pair per cycle, and emits clipped pixel
// writes to the VGA adapter. Cycle count is fixed regardless of clipping.
// Optional: DRAW_CROSSHAIR_ERASE_EN adds an erase input that switches the
// draw colour to BG_COLOUR for the whole draw.
module draw_crosshair_param
  import crosshair_pkg::*;
#(
  parameter int               ARM_LEN   = 3,
  parameter int               GAP       = 1,
  parameter int               THICK     = 1,
  parameter logic [COL_W-1:0] COLOUR    = 18'h3FFFF,
`ifdef DRAW_CROSSHAIR_ERASE_EN
  parameter logic [COL_W-1:0] BG_COLOUR = 18'h0,
`endif
  parameter int               SCREEN_W  = SCREEN_W_DFLT,
  parameter int               SCREEN_H  = SCREEN_H_DFLT
) (
  input  logic                   clock,
  input  logic                   reset,
  draw_crosshair_param_if.slave  cb
);

  localparam int                     D_W    = 6;
  localparam logic signed [D_W-1:0]  D_MAX  = D_W'(ARM_LEN);
  localparam logic signed [D_W-1:0]  D_MIN  = -D_MAX;
  localparam logic signed [D_W-1:0]  D_ONE  = D_W'(1);
  localparam logic signed [D_W-1:0]  GAP_S  = D_W'(GAP);
  localparam logic [2:0]             T_LAST = 3'(THICK - 1);
  localparam logic signed [SX_W-1:0] O_HALF = SX_W'((THICK - 1) / 2);

  state_t                  r_state;
  logic [2:0]              r_t;
  logic signed [D_W-1:0]   r_d;
  logic                    r_mode;
  logic [X_W-1:0]          r_cx;
  logic [Y_W-1:0]          r_cy;
  logic                    r_done;
  logic                    r_busy;
  logic                    r_vga_write;
  logic [X_W-1:0]          r_vga_x;
  logic [Y_W-1:0]          r_vga_y;
  logic [COL_W-1:0]        r_vga_colour;

  state_t                  w_nxt_state;
  logic [2:0]              w_nxt_t;
  logic signed [D_W-1:0]   w_nxt_d;
  logic                    w_emit;
  logic                    w_mode;
  logic [X_W-1:0]          w_cx;
  logic [Y_W-1:0]          w_cy;
  logic                    w_arm_b;
  logic signed [SX_W-1:0]  w_d9, w_o9, w_cx9, w_px;
  logic signed [SY_W-1:0]  w_d8, w_o8, w_cy8, w_py;
  logic signed [D_W-1:0]   w_dabs;
  logic                    w_gap_ok;
  logic                    w_inb;
  logic [X_W-1:0]          w_vx;
  logic [Y_W-1:0]          w_vy;
  logic                    w_wr;
  logic [COL_W-1:0]        w_colour;

  // Pick the pair whose pixel is registered at the coming edge; the start
  // cycle already yields the first pair so the draw has no idle lead-in.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_t     = r_t;
    w_nxt_d     = r_d;
    w_emit      = 1'b0;
    w_mode      = r_mode;
    w_cx        = r_cx;
    w_cy        = r_cy;
    unique case (r_state)
      IDLE: begin
        if (cb.start) begin
          w_nxt_state = ARM_A;
          w_nxt_t     = 3'd0;
          w_nxt_d     = D_MIN;
          w_emit      = 1'b1;
          w_mode      = cb.mode;
          w_cx        = cb.center_x;
          w_cy        = cb.center_y;
        end
      end
      ARM_A, ARM_B: begin
        if (r_d != D_MAX) begin
          w_nxt_d = r_d + D_ONE;
          w_emit  = 1'b1;
        end else if (r_t != T_LAST) begin
          w_nxt_t = r_t + 3'd1;
          w_nxt_d = D_MIN;
          w_emit  = 1'b1;
        end else if (r_state == ARM_A) begin
          w_nxt_state = ARM_B;
          w_nxt_t     = 3'd0;
          w_nxt_d     = D_MIN;
          w_emit      = 1'b1;
        end else begin
          w_nxt_state = FIN;
          w_nxt_t     = 3'd0;
          w_nxt_d     = '0;
        end
      end
      FIN:     w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  assign w_arm_b = (w_nxt_state == ARM_B);
  assign w_d9    = $signed({{(SX_W-D_W){w_nxt_d[D_W-1]}}, w_nxt_d});
  assign w_d8    = $signed({{(SY_W-D_W){w_nxt_d[D_W-1]}}, w_nxt_d});
  assign w_o9    = $signed({{(SX_W-3){1'b0}}, w_nxt_t}) - O_HALF;
  assign w_o8    = w_o9[SY_W-1:0];
  assign w_cx9   = $signed({1'b0, w_cx});
  assign w_cy8   = $signed({1'b0, w_cy});

  // Map (arm, t, d) to a signed screen coordinate for the selected shape
  always_comb begin
    w_px = w_cx9 + w_d9;
    w_py = w_cy8 + w_o8;
    if (!w_mode) begin
      if (w_arm_b) begin
        w_px = w_cx9 + w_o9;
        w_py = w_cy8 + w_d8;
      end
    end else begin
      w_px = w_cx9 + w_d9 + w_o9;
      w_py = w_arm_b ? (w_cy8 - w_d8) : (w_cy8 + w_d8);
    end
  end

  assign w_dabs   = w_nxt_d[D_W-1] ? -w_nxt_d : w_nxt_d;
  assign w_gap_ok = (w_dabs >= GAP_S);

  crosshair_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .i_x         (w_px),
    .i_y         (w_py),
    .o_in_bounds (w_inb),
    .o_x         (w_vx),
    .o_y         (w_vy)
  );

  assign w_wr = w_emit && w_gap_ok && w_inb;

`ifdef DRAW_CROSSHAIR_ERASE_EN
  logic r_erase;
  logic w_erase;
  // The erase choice is taken from the port on the start cycle itself
  assign w_erase  = (r_state == IDLE) ? cb.erase : r_erase;
  assign w_colour = w_erase ? BG_COLOUR : COLOUR;

  // Hold the erase choice for the remainder of the draw
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            r_erase <= 1'b0;
    else if (r_state == IDLE && cb.start) r_erase <= cb.erase;
  end
`else
  assign w_colour = COLOUR;
`endif

  // FSM, counters, latched draw request and registered VGA/handshake outputs;
  // pixel fields only update on writes so they hold between strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_t          <= 3'd0;
      r_d          <= '0;
      r_mode       <= 1'b0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_vga_write  <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_t         <= w_nxt_t;
      r_d         <= w_nxt_d;
      r_done      <= (w_nxt_state == FIN);
      r_busy      <= (w_nxt_state != IDLE);
      r_vga_write <= w_wr;
      if (r_state == IDLE && cb.start) begin
        r_mode <= cb.mode;
        r_cx   <= cb.center_x;
        r_cy   <= cb.center_y;
      end
      if (w_wr) begin
        r_vga_x      <= w_vx;
        r_vga_y      <= w_vy;
        r_vga_colour <= w_colour;
      end
    end
  end

  assign cb.done       = r_done;
  assign cb.busy       = r_busy;
  assign cb.vga_write  = r_vga_write;
  assign cb.vga_x      = r_vga_x;
  assign cb.vga_y      = r_vga_y;
  assign cb.vga_colour = r_vga_colour;

endmodule

// File: tb/tb_draw_crosshair_param.sv
// Directed bench for draw_crosshair_param: default-parameter instance plus a
// THICK=3/GAP=0/ARM_LEN=1 instance, with hand-listed expected pixel writes.
module tb_draw_crosshair_param;
  import crosshair_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  draw_crosshair_param_if bus0 ();
  draw_crosshair_param_if bus1 ();

  draw_crosshair_param u_dut0 (
    .clock (clock),
    .reset (reset),
    .cb    (bus0.slave)
  );

  draw_crosshair_param #(
    .ARM_LEN (1),
    .GAP     (0),
    .THICK   (3)
  ) u_dut1 (
    .clock (clock),
    .reset (reset),
    .cb    (bus1.slave)
  );

  int            n_chk = 0;
  int            n_fail = 0;
  logic [14:0]   wq[$];
  logic [14:0]   eq[$];
  int            done_cyc, done2_cyc, done_cnt, busy_cnt, first_wr, last_wr, col_bad;
  logic [17:0]   exp_col;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] px(input int x, input int y);
    return {8'(x), 7'(y)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int which, input logic s, input logic m, input int cx, input int cy);
    if (which == 0) begin
      bus0.start = s; bus0.mode = m; bus0.center_x = 8'(cx); bus0.center_y = 7'(cy);
    end else begin
      bus1.start = s; bus1.mode = m; bus1.center_x = 8'(cx); bus1.center_y = 7'(cy);
    end
  endtask

  task automatic clear_track();
    wq.delete();
    done_cyc = -1; done2_cyc = -1; done_cnt = 0; busy_cnt = 0;
    first_wr = -1; last_wr = -1; col_bad = 0;
  endtask

  task automatic sample(input int which, input int c);
    logic w, dn, bz;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [17:0] col;
    w   = (which == 0) ? bus0.vga_write  : bus1.vga_write;
    dn  = (which == 0) ? bus0.done       : bus1.done;
    bz  = (which == 0) ? bus0.busy       : bus1.busy;
    x   = (which == 0) ? bus0.vga_x      : bus1.vga_x;
    y   = (which == 0) ? bus0.vga_y      : bus1.vga_y;
    col = (which == 0) ? bus0.vga_colour : bus1.vga_colour;
    if (w) begin
      wq.push_back({x, y});
      if (first_wr < 0) first_wr = c;
      last_wr = c;
      if (col !== exp_col) col_bad++;
    end
    if (dn) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = c;
      else if (done2_cyc < 0) done2_cyc = c;
    end
    if (bz) busy_cnt++;
  endtask

  task automatic watch(input int which, input int ncyc);
    clear_track();
    for (int c = 1; c <= ncyc; c++) begin
      sample(which, c);
      step();
    end
  endtask

  // Pulse start for one cycle, then observe from cycle 1 onward
  task automatic run_draw(input int which, input logic m, input int cx, input int cy, input int ncyc);
    drive(which, 1'b1, m, cx, cy);
    step();
    drive(which, 1'b0, m, cx, cy);
    watch(which, ncyc);
  endtask

  task automatic cmp_q(input string tag);
    int n;
    chk({tag, ".count"}, 32'(wq.size()), 32'(eq.size()));
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.px%0d", tag, i), 32'(wq[i]), 32'(eq[i]));
  endtask

  // Default plus crosshair (ARM_LEN=3, GAP=1) around (cx,cy), hand-listed offsets
  task automatic exp_plus(input int cx, input int cy);
    eq.push_back(px(cx-3, cy)); eq.push_back(px(cx-2, cy)); eq.push_back(px(cx-1, cy));
    eq.push_back(px(cx+1, cy)); eq.push_back(px(cx+2, cy)); eq.push_back(px(cx+3, cy));
    eq.push_back(px(cx, cy-3)); eq.push_back(px(cx, cy-2)); eq.push_back(px(cx, cy-1));
    eq.push_back(px(cx, cy+1)); eq.push_back(px(cx, cy+2)); eq.push_back(px(cx, cy+3));
  endtask

  task automatic chk_timing(input string tag, input int exp_done, input int exp_busy);
    chk({tag, ".done_cyc"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, ".colour"},   32'(col_bad),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
`ifdef DRAW_CROSSHAIR_ERASE_EN
    bus0.erase = 1'b0;
    bus1.erase = 1'b0;
`endif
    exp_col = 18'h3FFFF;
    #2 reset = 1'b1;
    step();
    step();
    chk("rst.write",  32'(bus0.vga_write),  32'd0);
    chk("rst.done",   32'(bus0.done),       32'd0);
    chk("rst.busy",   32'(bus0.busy),       32'd0);
    chk("rst.xy",     32'({bus0.vga_x, bus0.vga_y}), 32'd0);
    chk("rst.colour", 32'(bus0.vga_colour), 32'd0);
    chk("rst.busy1",  32'(bus1.busy),       32'd0);
    reset = 1'b0;
    step();

    // Plus at (80,60)
    run_draw(0, 1'b0, 80, 60, 18);
    eq.delete(); exp_plus(80, 60);
    cmp_q("plus");
    chk_timing("plus", 15, 15);
    chk("plus.first_wr", 32'(first_wr), 32'd1);
    chk("plus.last_wr",  32'(last_wr),  32'd14);

    // X at (80,60)
    run_draw(0, 1'b1, 80, 60, 18);
    eq.delete();
    eq.push_back(px(77,57)); eq.push_back(px(78,58)); eq.push_back(px(79,59));
    eq.push_back(px(81,61)); eq.push_back(px(82,62)); eq.push_back(px(83,63));
    eq.push_back(px(77,63)); eq.push_back(px(78,62)); eq.push_back(px(79,61));
    eq.push_back(px(81,59)); eq.push_back(px(82,58)); eq.push_back(px(83,57));
    cmp_q("xmode");
    chk_timing("xmode", 15, 15);

    // Clipping at the top-left corner
    run_draw(0, 1'b0, 1, 0, 18);
    eq.delete();
    eq.push_back(px(0,0)); eq.push_back(px(2,0)); eq.push_back(px(3,0)); eq.push_back(px(4,0));
    eq.push_back(px(1,1)); eq.push_back(px(1,2)); eq.push_back(px(1,3));
    cmp_q("clip_tl");
    chk_timing("clip_tl", 15, 15);
    chk("clip_tl.first_wr", 32'(first_wr), 32'd3);

    // Clipping at the bottom-right corner
    run_draw(0, 1'b0, 158, 118, 18);
    eq.delete();
    eq.push_back(px(155,118)); eq.push_back(px(156,118)); eq.push_back(px(157,118)); eq.push_back(px(159,118));
    eq.push_back(px(158,115)); eq.push_back(px(158,116)); eq.push_back(px(158,117)); eq.push_back(px(158,119));
    cmp_q("clip_br");
    chk_timing("clip_br", 15, 15);

    // Reset during cycle 5 of a draw
    drive(0, 1'b1, 1'b0, 80, 60);
    step();
    drive(0, 1'b0, 1'b0, 80, 60);
    for (int i = 0; i < 4; i++) step();
    chk("abort.pre_write", 32'(bus0.vga_write), 32'd1);
    chk("abort.pre_x",     32'(bus0.vga_x),     32'd81);
    reset = 1'b1;
    #1;
    chk("abort.write",  32'(bus0.vga_write),  32'd0);
    chk("abort.busy",   32'(bus0.busy),       32'd0);
    chk("abort.done",   32'(bus0.done),       32'd0);
    chk("abort.xy",     32'({bus0.vga_x, bus0.vga_y}), 32'd0);
    chk("abort.colour", 32'(bus0.vga_colour), 32'd0);
    step();
    reset = 1'b0;
    watch(0, 20);
    chk("abort.no_done",  32'(done_cnt),   32'd0);
    chk("abort.no_write", 32'(wq.size()),  32'd0);
    chk("abort.no_busy",  32'(busy_cnt),   32'd0);
    run_draw(0, 1'b0, 80, 60, 18);
    eq.delete(); exp_plus(80, 60);
    cmp_q("redraw");
    chk_timing("redraw", 15, 15);

    // start held through FIN; center_x changes mid-draw
    clear_track();
    drive(0, 1'b1, 1'b0, 80, 60);
    step();
    for (int c = 1; c <= 34; c++) begin
      sample(0, c);
      if (c == 3)  bus0.center_x = 8'd20;
      if (c == 31) bus0.start = 1'b0;
      step();
    end
    eq.delete(); exp_plus(80, 60); exp_plus(20, 60);
    cmp_q("held");
    chk("held.done1",    32'(done_cyc),  32'd15);
    chk("held.done2",    32'(done2_cyc), 32'd31);
    chk("held.done_cnt", 32'(done_cnt),  32'd2);
    chk("held.busy_cnt", 32'(busy_cnt),  32'd30);
    step();

    // THICK=3, GAP=0, ARM_LEN=1 plus at (10,10)
    run_draw(1, 1'b0, 10, 10, 24);
    eq.delete();
    eq.push_back(px(9,9));  eq.push_back(px(10,9));  eq.push_back(px(11,9));
    eq.push_back(px(9,10)); eq.push_back(px(10,10)); eq.push_back(px(11,10));
    eq.push_back(px(9,11)); eq.push_back(px(10,11)); eq.push_back(px(11,11));
    eq.push_back(px(9,9));  eq.push_back(px(9,10));  eq.push_back(px(9,11));
    eq.push_back(px(10,9)); eq.push_back(px(10,10)); eq.push_back(px(10,11));
    eq.push_back(px(11,9)); eq.push_back(px(11,10)); eq.push_back(px(11,11));
    cmp_q("thick3");
    chk_timing("thick3", 19, 19);

`ifdef DRAW_CROSSHAIR_ERASE_EN
    // Erase draw uses the background colour with identical pixels and timing
    bus0.erase = 1'b1;
    exp_col = 18'h0;
    run_draw(0, 1'b0, 80, 60, 18);
    bus0.erase = 1'b0;
    eq.delete(); exp_plus(80, 60);
    cmp_q("erase");
    chk_timing("erase", 15, 15);
    exp_col = 18'h3FFFF;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_crosshair_param.md
Name: draw_crosshair_param

Overview:
- Parametrised successor of the fixed crosshair drawer.
- On a start pulse it rasterises a crosshair around a pixel-space centre, one pixel per cycle, into the VGA adapter write port.
- Arm length, centre gap, thickness and colour are configurable. Plus and diagonal (X) shapes are selectable per draw.
- Pixels off the 160x120 screen are clipped, not wrapped.
- Sits between the game-state renderer and the VGA adapter mux, alongside the other draw_* blocks.

Parameters:
- ARM_LEN, 3, arm half-length in pixels (1..15).
- GAP, 1, pixels with |d| < GAP are skipped (0 = solid centre).
- THICK, 1, arm thickness in pixels; must be odd (1..7).
- COLOUR, 18'h3FFFF, draw colour.
- SCREEN_W, 160, visible width.
- SCREEN_H, 120, visible height.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a draw; sampled only in IDLE
- mode  in  1  0 = plus, 1 = X; latched with start
- center_x  in  8  centre column, pixels; latched with start
- center_y  in  7  centre row, pixels; latched with start
- done  out  1  one-cycle pulse when the draw completes
- busy  out  1  high from the cycle after start until done, inclusive
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- vga_colour  out  18  pixel colour
- vga_write  out  1  write strobe for vga_x/vga_y/vga_colour

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All outputs are 0, state is IDLE, counters are 0. Reset mid-draw aborts immediately; no done pulse is produced.
- All outputs are registered.
- FSM states: IDLE -> ARM_A -> ARM_B -> FIN -> IDLE.
  - IDLE: start=1 latches mode, center_x and center_y, clears counters, moves to ARM_A.
  - ARM_A: counters t (0..THICK-1, outer loop) and d (-ARM_LEN..+ARM_LEN, inner loop). Steps one (t, d) per cycle; leaves after the last pair.
  - ARM_B: same counter sequence as ARM_A.
  - FIN: done=1 for one cycle, then IDLE.
- Offset: o = t - (THICK-1)/2.
- Plus mode:
  - ARM_A pixel = (cx+d, cy+o).
  - ARM_B pixel = (cx+o, cy+d).
- X mode:
  - ARM_A pixel = (cx+d+o, cy+d).
  - ARM_B pixel = (cx+d+o, cy-d).
- Arithmetic: coordinates are computed signed, 9-bit for x and 8-bit for y.
- vga_write=1 only when |d| >= GAP, 0 <= x < SCREEN_W and 0 <= y < SCREEN_H. Otherwise the cycle is still consumed with vga_write=0, so the cycle count is fixed.
- Cycle count is deterministic. With N = 2*THICK*(2*ARM_LEN+1):
  - First pixel is valid after the edge following start.
  - Last pixel is valid N cycles after start.
  - done is high in cycle N+1.
- vga_x, vga_y and vga_colour are don't-care when vga_write=0, but hold their last values.
- vga_colour = COLOUR.
- start is ignored outside IDLE, including the FIN cycle. start in the first cycle after FIN is accepted.
- A centre pixel drawn by both arms (GAP=0) is written twice; this is legal.

Optional Feature:
- Macro: DRAW_CROSSHAIR_ERASE_EN.
- Defined:
  - Adds input port erase (1 bit), latched with start.
  - Adds parameter BG_COLOUR, default 18'h0.
  - If the latched erase is 1, vga_colour = BG_COLOUR; pixel sequence and timing are unchanged.
- Undefined: the erase port and BG_COLOUR do not exist; colour is always COLOUR.

Decomposition:
- Package crosshair_pkg:
  - state enum {IDLE, ARM_A, ARM_B, FIN}
  - SCREEN_W and SCREEN_H defaults
  - X_W=8, Y_W=7, COL_W=18
  - signed coordinate widths 9 and 8
- One sub-module: crosshair_clip. It is combinational: it takes signed x/y and returns the in-bounds flag and truncated vga_x/vga_y. It is reused by future draw_* blocks.

Test Plan:
- Default parameters, plus, centre (80,60), start for 1 cycle:
  - 14 draw cycles.
  - Writes (77,60), (78,60), (79,60), (81,60), (82,60), (83,60) in ARM_A, then x=80 with y=57, 58, 59, 61, 62, 63 in ARM_B.
  - done pulses in cycle 15; busy falls after it.
- X mode, centre (80,60): ARM_A writes (77,57)..(83,63) skipping (80,60); ARM_B writes (77,63)..(83,57) skipping centre.
- Clipping, centre (1,0), plus:
  - Pixels at x=-2, x=-1 and y=-3..-1 have vga_write=0.
  - Total cycles stay 14; (0,0), (2,0), (3,0), (4,0), (1,1), (1,2), (1,3) are written.
- Reset asserted in cycle 5 of a draw: outputs are 0 within the same cycle, no done pulse. A new start afterwards draws the full 14-cycle sequence.
- start held high through FIN: a second draw begins the cycle after done with no gap. Changing center_x mid-draw does not affect the current draw.
- THICK=3, GAP=0, ARM_LEN=1, plus, centre (10,10): 18 writes covering rows 9..11 at x=9..11 (ARM_A) and columns 9..11 at y=9..11 (ARM_B).
